// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture buffer: FSM states, register map,
// CTRL bit positions and STATUS field layout.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_TRIG   = 3'd2;
  localparam logic [2:0] ADDR_DATA   = 3'd3;
  localparam logic [2:0] ADDR_DECIM  = 3'd4;

  localparam int CTRL_ARM_BIT     = 0;
  localparam int CTRL_TRIG_EN_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_DONE_BIT  = 2;
  localparam int STAT_COUNT_LSB = 16;

  function automatic logic [31:0] pack_status(input cap_state_t st, input logic [15:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 2]  = st;
    s[STAT_DONE_BIT]        = (st == ST_DONE);
    s[STAT_COUNT_LSB +: 16] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read, written so
// the fitter maps it onto block RAM.
module adc_cap_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture buffer with an Avalon-MM slave for arm/status/readback.
// Optional sample decimation is compiled in with `define ADC_CAP_DECIM_EN.
module adc_capture_buffer
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1024,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              capture_done
);

  localparam int CNT_W = PTR_W + 1;

  cap_state_t        state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              trig_en;
  logic [DATA_W-1:0] trig_level;
  logic [DATA_W-1:0] prev;
  logic              prev_ok;
  logic [31:0]       readdata_reg;
  logic              data_sel;
  logic [DATA_W-1:0] ram_q;

`ifdef ADC_CAP_DECIM_EN
  logic [15:0] decim_reg;
  logic [15:0] decim_cnt;
`endif

  logic              ctrl_wr;
  logic              ctrl_abort;
  logic              ctrl_arm;
  logic              trig_hit;
  logic              decim_ok;
  logic              cap_accept;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_comb begin
    ctrl_wr    = avs_write && (avs_address == ADDR_CTRL);
    ctrl_abort = ctrl_wr && avs_writedata[CTRL_ABORT_BIT];
    ctrl_arm   = ctrl_wr && avs_writedata[CTRL_ARM_BIT] && !avs_writedata[CTRL_ABORT_BIT];
    trig_hit   = sample_valid && (state == ST_ARMED) && prev_ok &&
                 (prev < trig_level) && (sample_data >= trig_level);
`ifdef ADC_CAP_DECIM_EN
    decim_ok   = (decim_cnt == 16'd0);
`else
    decim_ok   = 1'b1;
`endif
    cap_accept = sample_valid && (state == ST_CAPTURE) && decim_ok;
    // A control action in the same cycle pre-empts any sample write.
    ram_we     = !(ctrl_abort || ctrl_arm) && (trig_hit || cap_accept);
    ram_waddr  = trig_hit ? '0 : wr_ptr;
  end

  adc_cap_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(sample_data),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );

  // DATA reads come straight from the RAM output register to keep latency at one.
  assign avs_readdata = data_sel ? 32'(ram_q) : readdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      trig_en           <= 1'b0;
      trig_level        <= '0;
      prev              <= '0;
      prev_ok           <= 1'b0;
      readdata_reg      <= '0;
      data_sel          <= 1'b0;
      avs_readdatavalid <= 1'b0;
      capture_done      <= 1'b0;
`ifdef ADC_CAP_DECIM_EN
      decim_reg         <= '0;
      decim_cnt         <= '0;
`endif
    end else begin
      avs_readdatavalid <= avs_read;
      readdata_reg      <= '0;
      data_sel          <= 1'b0;

      if (avs_read) begin
        case (avs_address)
          ADDR_CTRL:   readdata_reg[CTRL_TRIG_EN_BIT] <= trig_en;
          ADDR_STATUS: readdata_reg <= pack_status(state, 16'(count));
          ADDR_TRIG:   readdata_reg <= 32'(trig_level);
          ADDR_DATA: begin
            if (state == ST_DONE) begin
              data_sel <= 1'b1;
              rd_ptr   <= rd_ptr + 1'b1;
            end
          end
`ifdef ADC_CAP_DECIM_EN
          ADDR_DECIM:  readdata_reg <= 32'(decim_reg);
`endif
          default: ;
        endcase
      end

      if (avs_write && (avs_address == ADDR_TRIG))
        trig_level <= avs_writedata[DATA_W-1:0];
`ifdef ADC_CAP_DECIM_EN
      if (avs_write && (avs_address == ADDR_DECIM))
        decim_reg <= avs_writedata[15:0];
`endif
      if (ctrl_wr)
        trig_en <= avs_writedata[CTRL_TRIG_EN_BIT];

      if (ctrl_abort) begin
        state        <= ST_IDLE;
        capture_done <= 1'b0;
      end else if (ctrl_arm) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        prev_ok      <= 1'b0;
        capture_done <= 1'b0;
        state        <= avs_writedata[CTRL_TRIG_EN_BIT] ? ST_ARMED : ST_CAPTURE;
`ifdef ADC_CAP_DECIM_EN
        decim_cnt    <= '0;
`endif
      end else if (sample_valid) begin
        case (state)
          ST_ARMED: begin
            prev    <= sample_data;
            prev_ok <= 1'b1;
            if (trig_hit) begin
              // Triggering sample has landed at index 0.
              wr_ptr <= PTR_W'(1);
              count  <= CNT_W'(1);
              state  <= ST_CAPTURE;
`ifdef ADC_CAP_DECIM_EN
              decim_cnt <= (decim_reg == 16'd0) ? 16'd0 : 16'd1;
`endif
            end
          end
          ST_CAPTURE: begin
`ifdef ADC_CAP_DECIM_EN
            decim_cnt <= (decim_cnt >= decim_reg) ? 16'd0 : decim_cnt + 16'd1;
`endif
            if (cap_accept) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
              if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                state        <= ST_DONE;
                capture_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
